// File: rtl/mac_row4_ctrl_if.sv
// Handshake bundle between the job sequencer and its environment:
// one weight-set port, one sample port and the buffered result port.
interface mac_row4_ctrl_if #(
  parameter int FP_W = 16
);
  logic              w_valid;
  logic              w_ready;
  logic [4*FP_W-1:0] w_data;
  logic              x_valid;
  logic              x_ready;
  logic [FP_W-1:0]   x_data;
  logic              y_valid;
  logic              y_ready;
  logic [FP_W-1:0]   y_data;
  logic              y_last;

  modport master (
    output w_valid, w_data, x_valid, x_data, y_ready,
    input  w_ready, x_ready, y_valid, y_data, y_last
  );

  modport slave (
    input  w_valid, w_data, x_valid, x_data, y_ready,
    output w_ready, x_ready, y_valid, y_data, y_last
  );
endinterface

// File: rtl/mac_row4_ctrl.sv
// Job sequencer for the 4-stage FP16 systolic row: loads a weight set, streams
// samples, and buffers row results in a credit-protected FIFO.
module mac_row4_ctrl #(
  parameter int FP_W        = 16,
  parameter int LEN_W       = 8,
  parameter int OFIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              ovf_flag,
  mac_row4_ctrl_if.slave    bus,
  output logic [3:0]        enW,
  output logic [FP_W-1:0]   W0_o,
  output logic [FP_W-1:0]   W1_o,
  output logic [FP_W-1:0]   W2_o,
  output logic [FP_W-1:0]   W3_o,
  output logic              enX,
  output logic [FP_W-1:0]   X_o,
  input  logic [FP_W-1:0]   Y_i,
  input  logic              finish_i
);
  localparam int CNT_W = LEN_W + 1;
  localparam int SUM_W = CNT_W + 1;
  localparam int AW    = $clog2(OFIFO_DEPTH);
  localparam int OCC_W = AW + 1;

  typedef enum logic [2:0] {ST_IDLE, ST_LOADW, ST_STREAM, ST_DRAIN, ST_DONE} state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_len;
  logic [CNT_W-1:0]    r_issued;
  logic [CNT_W-1:0]    r_received;
  logic                r_done;
  logic                r_ovf;
  logic [3:0]          r_enw;
  logic [4*FP_W-1:0]   r_w;
  logic                r_enx;
  logic [FP_W-1:0]     r_x;
  logic [FP_W:0]       r_mem [OFIFO_DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [OCC_W-1:0]    r_count;

  logic [CNT_W-1:0]    w_outstanding;
  logic [SUM_W-1:0]    w_inflight;
  logic                w_empty;
  logic                w_x_ready;
  logic                w_x_fire;
  logic                w_w_fire;
  logic                w_push;
  logic                w_pop;
  logic                w_push_last;

  assign w_outstanding = r_issued - r_received;
  // Credits: results in flight in the row plus results already buffered.
  assign w_inflight    = SUM_W'(w_outstanding) + SUM_W'(r_count);
  assign w_empty       = (r_count == '0);
  assign w_x_ready     = (r_state == ST_STREAM) && (r_issued < r_len) &&
                         (w_inflight < SUM_W'(OFIFO_DEPTH));
  assign w_x_fire      = bus.x_valid && w_x_ready;
  assign w_w_fire      = bus.w_valid && (r_state == ST_LOADW);
  assign w_push        = finish_i && (w_outstanding != '0) && (r_state != ST_IDLE);
  assign w_pop         = !w_empty && bus.y_ready;
  assign w_push_last   = (r_received == r_len - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_len      <= '0;
      r_issued   <= '0;
      r_received <= '0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
      r_enw      <= '0;
      r_w        <= '0;
      r_enx      <= 1'b0;
      r_x        <= '0;
    end else begin
      r_enw  <= w_w_fire ? 4'b1111 : 4'b0000;
      r_enx  <= w_x_fire;
      r_done <= (r_state == ST_DONE);
      if (w_w_fire) r_w <= bus.w_data;
      if (w_x_fire) begin
        r_x      <= bus.x_data;
        r_issued <= r_issued + CNT_W'(1);
      end
      if (w_push) begin
        r_received <= r_received + CNT_W'(1);
        if (Y_i[FP_W-2 -: 5] == 5'h1F) r_ovf <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_len      <= CNT_W'(len);
            r_issued   <= '0;
            r_received <= '0;
            r_ovf      <= 1'b0;
            r_state    <= ST_LOADW;
          end
        end
        ST_LOADW: begin
          if (w_w_fire) r_state <= (r_len == '0) ? ST_DONE : ST_STREAM;
        end
        ST_STREAM: begin
          if (w_x_fire && (r_issued + CNT_W'(1) == r_len)) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (r_received == r_len) r_state <= ST_DONE;
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Storage needs no reset; occupancy alone defines what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {w_push_last, Y_i};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + OCC_W'(w_push) - OCC_W'(w_pop);
    end
  end

  assign busy        = (r_state != ST_IDLE);
  assign done        = r_done;
  assign ovf_flag    = r_ovf;
  assign bus.w_ready = (r_state == ST_LOADW);
  assign bus.x_ready = w_x_ready;
  assign bus.y_valid = !w_empty;
  assign bus.y_data  = w_empty ? '0 : r_mem[r_rd_ptr][FP_W-1:0];
  assign bus.y_last  = w_empty ? 1'b0 : r_mem[r_rd_ptr][FP_W];
  assign enW         = r_enw;
  assign W0_o        = r_w[0*FP_W +: FP_W];
  assign W1_o        = r_w[1*FP_W +: FP_W];
  assign W2_o        = r_w[2*FP_W +: FP_W];
  assign W3_o        = r_w[3*FP_W +: FP_W];
  assign enX         = r_enx;
  assign X_o         = r_x;
endmodule

// File: doc/mac_row4_ctrl.md
Name: mac_row4_ctrl

Overview:
Job sequencer for the 4-stage FP16 systolic row mac_row4. It accepts a start command with a sample count, loads one 4-weight set through a valid/ready port and pulses enW for that load. It then streams X samples into the row with enX, captures each Y result flagged by finish, and returns the results through a buffered valid/ready output. Credit-based flow control means a downstream stall can never drop a row result.

Parameters:
FP_W, 16, FP16 word width
LEN_W, 8, width of the sample-count field
OFIFO_DEPTH, 8, result FIFO entries (power of 2, ≥2); also the maximum number of in-flight results

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active-low
start  in  1  job start; accepted only in IDLE
len  in  LEN_W  number of X samples in the job; sampled on an accepted start
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse at job completion
ovf_flag  out  1  sticky; set when a captured Y has exponent 5'h1F (Inf/NaN); cleared on an accepted start
w_valid  in  1  weight set valid
w_ready  out  1  weight set ready
w_data  in  4*FP_W  {W3,W2,W1,W0}, with W0 in [FP_W-1:0]
x_valid  in  1  sample valid
x_ready  out  1  sample ready
x_data  in  FP_W  X sample
y_valid  out  1  result valid (FIFO not empty)
y_ready  in  1  result ready
y_data  out  FP_W  result (FIFO head)
y_last  out  1  high with the final result of the job
enW  out  4  weight-load enables to the row
W0_o..W3_o  out  FP_W each  weights to the row
enX  out  1  sample enable to the row
X_o  out  FP_W  sample to the row
Y_i  in  FP_W  row output
finish_i  in  1  row result-valid strobe

Behaviour:
- Reset (rst_n low at a clk edge) clears everything: state=IDLE, busy/done/ovf_flag/w_ready/x_ready/y_valid/y_last=0, enW=0, enX=0, all W*_o/X_o=0, counters=0, FIFO empty.
- States: IDLE, LOADW, STREAM, DRAIN, DONE.
- IDLE:
  - start=1 latches len, clears issued/received counters, clears ovf_flag, then goes to LOADW.
  - start in any other state is ignored.
- LOADW:
  - w_ready=1.
  - On w_valid&w_ready, the next cycle drives enW=4'b1111 for exactly one cycle, with W*_o registered from w_data.
  - Next state is STREAM, or DONE if len==0.
  - W*_o hold their value until the next load.
- STREAM:
  - x_ready = (issued<len) && ((issued-received)+fifo_count < OFIFO_DEPTH).
  - On each x handshake, the next cycle drives enX=1 and X_o=x_data, and issued increments. enX=0 on every cycle without a handshake.
  - X_o holds its last value when idle.
  - When the final sample is accepted (issued reaches len), go to DRAIN.
- DRAIN:
  - x_ready=0.
  - When received==len, go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Result capture, active in every non-IDLE state:
  - finish_i with (issued-received)>0 pushes Y_i into the FIFO and increments received.
  - The entry is tagged last when received==len-1 at the push.
  - Y_i[14:10]==5'h1F sets ovf_flag.
  - finish_i with zero outstanding results is ignored: no push, no count change.
- Credit rule: at most OFIFO_DEPTH results are in flight or buffered, so a push never meets a full FIFO. Simultaneous push and pop is legal at any occupancy.
- FIFO output:
  - y_valid=!empty; y_data/y_last come from the head.
  - A pop occurs on y_valid&y_ready.
  - Results leave in issue order.
  - Results remaining in the FIFO may still drain after done and into the next job.
- Counters are LEN_W+1 bits wide; no wrap-around within a job.
- Mid-job reset aborts immediately. Results the row produces after reset are ignored, because outstanding is 0.

Test Plan:
1. Known run, with the row stub asserting finish a fixed 4 cycles after enX:
   - Stimulus: start, len=4; w_data={4200,4000,3800,3C00}; x=3C00 for 4 back-to-back cycles.
   - Required: enW=1111 for exactly one cycle; enX high for 4 consecutive cycles; 4 y beats in order, with y_last on the 4th only; a single done pulse; busy=0 after done.
2. Backpressure, with OFIFO_DEPTH=8:
   - Stimulus: len=20; y_ready=0; x_valid held high.
   - Required: x_ready drops after 8 issues and no further enX occurs; release y_ready → all 20 results arrive in order, none lost or duplicated; y_last on the 20th.
3. Sparse input:
   - Stimulus: x_valid toggles 1,0,0,1,…
   - Required: enX asserts only in the cycle after each handshake; X_o equals the accepted sample; the job completes with issued==received==len.
4. Zero-length job:
   - Stimulus: start, len=0, then one weight beat.
   - Required: enW pulses once; no enX; done pulses 1 cycle after the enW pulse; no y beats.
5. Overflow weight:
   - Stimulus: W0=7C00; the stub returns Y=7C00.
   - Required: ovf_flag=1 and stays set through DONE; the next accepted start clears it.
6. Reset mid-STREAM:
   - Stimulus: after 3 of 6 issues, hold rst_n=0 for one edge.
   - Required: all outputs 0 and FIFO empty at that edge; stray finish_i is ignored; a new start runs a clean job.
